// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline control unit for the five-stage core (IF/ID/EX/MEM/WB).
//
// Owns the control-register file read by the decoder, derives per-stage
// stall/flush from bus waits, load-use hazards, taken branches and MEM-stage
// exceptions, and sequences exception entry / return (EXRT) by redirecting
// fetch through new_pc.
//
// Ports:
//   clk, reset          core clock; synchronous active-low reset
//   irq[7:0]            level interrupt requests
//   if_busy, mem_busy   bus wait from IF / MEM (global stall)
//   ld_hazard           load-use hazard from the decoder
//   id_br_taken         taken branch resolved in ID
//   creg_rd_addr/data   decoder control-register read port (combinational)
//   exe_mode            0 = kernel, 1 = user
//   int_detect          unmasked interrupt pending
//   mem_*               MEM-stage pipeline register contents
//   *_stall, *_flush    per-stage hold / invalidate
//   new_pc              fetch redirect target (word address), valid with if_flush

module pipe_ctrl #(
   parameter logic [29:0] RESET_VECTOR   = 30'h0,
   parameter logic [29:0] EXP_VECTOR_RST = 30'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  irq,
   input  logic        if_busy,
   input  logic        mem_busy,
   input  logic        ld_hazard,
   input  logic        id_br_taken,
   input  logic [4:0]  creg_rd_addr,
   output logic [31:0] creg_rd_data,
   output logic        exe_mode,
   output logic        int_detect,
   input  logic        mem_en,
   input  logic [29:0] mem_pc,
   input  logic        mem_br_flag,
   input  logic [1:0]  mem_ctrl_op,
   input  logic [4:0]  mem_dst_addr,
   input  logic [2:0]  mem_exp_code,
   input  logic [31:0] mem_out,
   output logic        if_stall,
   output logic        id_stall,
   output logic        ex_stall,
   output logic        mem_stall,
   output logic        if_flush,
   output logic        id_flush,
   output logic        ex_flush,
   output logic        mem_flush,
   output logic [29:0] new_pc
);

   // Reset-release sequencer states
   localparam logic [1:0] ST_RST  = 2'd0;
   localparam logic [1:0] ST_BOOT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // Control-register addresses
   localparam logic [4:0] CR_STATUS     = 5'd0;
   localparam logic [4:0] CR_PRE_STATUS = 5'd1;
   localparam logic [4:0] CR_PC         = 5'd2;
   localparam logic [4:0] CR_EXP_VECTOR = 5'd3;
   localparam logic [4:0] CR_CAUSE      = 5'd4;
   localparam logic [4:0] CR_INT_MASK   = 5'd5;
   localparam logic [4:0] CR_IRQ        = 5'd6;
   localparam logic [4:0] CR_EPC        = 5'd7;

   localparam logic [1:0] OP_WRCR = 2'd1;
   localparam logic [1:0] OP_EXRT = 2'd2;

   logic [1:0]  r_state;
   logic [1:0]  r_status;      // {int_en, exe_mode}
   logic [1:0]  r_pre_status;
   logic [29:0] r_pc;
   logic [29:0] r_exp_vector;
   logic [3:0]  r_cause;       // {dly, exp_code}
   logic [7:0]  r_int_mask;
   logic [29:0] r_epc;

   logic        w_stall;
   logic        w_exp;
   logic        w_exrt;
   logic        w_wrcr;
   logic        w_run;
   logic [29:0] w_epc_next;

   assign w_stall = if_busy | mem_busy;
   assign w_exp   = mem_en & (mem_exp_code != 3'd0);
   assign w_exrt  = mem_en & (mem_ctrl_op == OP_EXRT) & (mem_exp_code == 3'd0);
   assign w_wrcr  = mem_en & (mem_ctrl_op == OP_WRCR) & (mem_exp_code == 3'd0);
   assign w_run   = (r_state == ST_RUN);

   // A fault in a delay slot must resume at the branch, one word back (wraps at 0)
   assign w_epc_next = mem_br_flag ? (mem_pc - 30'd1) : mem_pc;

   assign exe_mode   = r_status[0];
   assign int_detect = r_status[1] & (|(irq & ~r_int_mask));

   // Stall / flush / redirect generation, highest-priority event wins
   always_comb begin
      if_stall  = 1'b0;
      id_stall  = 1'b0;
      ex_stall  = 1'b0;
      mem_stall = 1'b0;
      if_flush  = 1'b0;
      id_flush  = 1'b0;
      ex_flush  = 1'b0;
      mem_flush = 1'b0;
      new_pc    = 30'd0;
      case (r_state)
         ST_RST: begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
         end
         ST_BOOT: begin
            if_flush = 1'b1;
            new_pc   = RESET_VECTOR;
         end
         ST_RUN: begin
            if (w_stall) begin
               // A pending exception is simply held off until the bus frees up
               if_stall  = 1'b1;
               id_stall  = 1'b1;
               ex_stall  = 1'b1;
               mem_stall = 1'b1;
            end else if (w_exp) begin
               if_flush  = 1'b1;
               id_flush  = 1'b1;
               ex_flush  = 1'b1;
               mem_flush = 1'b1;
               new_pc    = r_exp_vector;
            end else if (w_exrt) begin
               if_flush  = 1'b1;
               id_flush  = 1'b1;
               ex_flush  = 1'b1;
               mem_flush = 1'b1;
               new_pc    = r_epc;
            end else if (w_wrcr) begin
               // Register write only; it outranks branch and hazard handling
               if_flush = 1'b0;
            end else if (id_br_taken) begin
               // IF performs the redirect itself; only the delay slot is killed
               if_flush = 1'b1;
            end else if (ld_hazard) begin
               // Hold IF/ID and push a bubble into EX
               if_stall = 1'b1;
               id_stall = 1'b1;
               id_flush = 1'b1;
            end else begin
               if_flush = 1'b0;
            end
         end
         default: begin
            if_flush  = 1'b1;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
            mem_flush = 1'b1;
         end
      endcase
   end

   // Decoder read port; unused bits and unmapped addresses read 0
   always_comb begin
      creg_rd_data = 32'd0;
      case (creg_rd_addr)
         CR_STATUS:     creg_rd_data = {30'd0, r_status};
         CR_PRE_STATUS: creg_rd_data = {30'd0, r_pre_status};
         CR_PC:         creg_rd_data = {r_pc, 2'b00};
         CR_EXP_VECTOR: creg_rd_data = {r_exp_vector, 2'b00};
         CR_CAUSE:      creg_rd_data = {28'd0, r_cause};
         CR_INT_MASK:   creg_rd_data = {24'd0, r_int_mask};
         CR_IRQ:        creg_rd_data = {24'd0, irq};
         CR_EPC:        creg_rd_data = {r_epc, 2'b00};
         default:       creg_rd_data = 32'd0;
      endcase
   end

   // Reset-release sequencer: RST -> BOOT (one cycle) -> RUN
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_RST;
      end else begin
         case (r_state)
            ST_RST:  r_state <= ST_BOOT;
            ST_BOOT: r_state <= ST_RUN;
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_RST;
         endcase
      end
   end

   // Control-register file: exception entry, EXRT and WRCR updates
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_status     <= 2'b00;
         r_pre_status <= 2'b00;
         r_pc         <= 30'd0;
         r_exp_vector <= EXP_VECTOR_RST;
         r_cause      <= 4'd0;
         r_int_mask   <= 8'hFF;
         r_epc        <= 30'd0;
      end else if (w_run && !w_stall) begin
         if (w_exp) begin
            r_pre_status <= r_status;
            r_status     <= 2'b00;
            r_cause      <= {mem_br_flag, mem_exp_code};
            r_epc        <= w_epc_next;
         end else if (w_exrt) begin
            r_status <= r_pre_status;
         end else if (w_wrcr) begin
            case (mem_dst_addr)
               CR_STATUS:     r_status     <= mem_out[1:0];
               CR_PRE_STATUS: r_pre_status <= mem_out[1:0];
               CR_PC:         r_pc         <= mem_out[31:2];
               CR_EXP_VECTOR: r_exp_vector <= mem_out[31:2];
               CR_CAUSE:      r_cause      <= mem_out[3:0];
               CR_INT_MASK:   r_int_mask   <= mem_out[7:0];
               CR_EPC:        r_epc        <= mem_out[31:2];
               default:       r_status     <= r_status;   // IRQ and 8..31 are not writable
            endcase
         end else begin
            r_status <= r_status;
         end
      end else begin
         r_status <= r_status;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: a table of combinational
// priority vectors plus hand-written multi-cycle sequences.

module tb_pipe_ctrl;

   localparam logic [29:0] RV  = 30'h0000_1230;
   localparam logic [29:0] EVR = 30'h0000_0020;

   logic        clk;
   logic        reset;
   logic [7:0]  irq;
   logic        if_busy, mem_busy, ld_hazard, id_br_taken;
   logic [4:0]  creg_rd_addr;
   logic [31:0] creg_rd_data;
   logic        exe_mode, int_detect;
   logic        mem_en;
   logic [29:0] mem_pc;
   logic        mem_br_flag;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;
   logic        if_stall, id_stall, ex_stall, mem_stall;
   logic        if_flush, id_flush, ex_flush, mem_flush;
   logic [29:0] new_pc;

   logic [3:0]  stalls, flushes;
   assign stalls  = {if_stall, id_stall, ex_stall, mem_stall};
   assign flushes = {if_flush, id_flush, ex_flush, mem_flush};

   int errors = 0;
   int checks = 0;

   pipe_ctrl #(.RESET_VECTOR(RV), .EXP_VECTOR_RST(EVR)) dut (
      .clk(clk), .reset(reset), .irq(irq),
      .if_busy(if_busy), .mem_busy(mem_busy), .ld_hazard(ld_hazard),
      .id_br_taken(id_br_taken), .creg_rd_addr(creg_rd_addr),
      .creg_rd_data(creg_rd_data), .exe_mode(exe_mode), .int_detect(int_detect),
      .mem_en(mem_en), .mem_pc(mem_pc), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr),
      .mem_exp_code(mem_exp_code), .mem_out(mem_out),
      .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
      .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
      .new_pc(new_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        ifb, memb, ldh, br, en;
      logic [1:0]  op;
      logic [2:0]  code;
      logic [3:0]  e_stall;
      logic [3:0]  e_flush;
      logic [29:0] e_pc;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic rd(input string name, input logic [4:0] a, input logic [31:0] e);
      creg_rd_addr = a;
      #1;
      chk(name, creg_rd_data, e);
   endtask

   task automatic idle();
      if_busy = 1'b0; mem_busy = 1'b0; ld_hazard = 1'b0; id_br_taken = 1'b0;
      mem_en = 1'b0; mem_pc = 30'd0; mem_br_flag = 1'b0; mem_ctrl_op = 2'd0;
      mem_dst_addr = 5'd0; mem_exp_code = 3'd0; mem_out = 32'd0;
   endtask

   task automatic wrcr(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = a; mem_out = d;
      @(negedge clk);
      idle();
   endtask

   initial begin
      // name, ifb, memb, ldh, br, en, op, code, stall, flush, new_pc
      tbl[0]  = '{"idle",          1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,4'h0,4'h0,30'h0};
      tbl[1]  = '{"if_busy",       1'b1,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,4'hF,4'h0,30'h0};
      tbl[2]  = '{"mem_busy",      1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,3'd0,4'hF,4'h0,30'h0};
      tbl[3]  = '{"busy_exp",      1'b0,1'b1,1'b0,1'b0,1'b1,2'd0,3'd5,4'hF,4'h0,30'h0};
      tbl[4]  = '{"ld_hazard",     1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd0,4'hC,4'h4,30'h0};
      tbl[5]  = '{"branch",        1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,3'd0,4'h0,4'h8,30'h0};
      tbl[6]  = '{"branch_ld",     1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,3'd0,4'h0,4'h8,30'h0};
      tbl[7]  = '{"exp_ld",        1'b0,1'b0,1'b1,1'b0,1'b1,2'd0,3'd5,4'h0,4'hF,30'h100};
      tbl[8]  = '{"exrt",          1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd0,4'h0,4'hF,30'h80};
      tbl[9]  = '{"exrt_exp",      1'b0,1'b0,1'b0,1'b0,1'b1,2'd2,3'd2,4'h0,4'hF,30'h100};
      tbl[10] = '{"exp_no_en",     1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd3,4'h0,4'h0,30'h0};
      tbl[11] = '{"exrt_no_en_br", 1'b0,1'b0,1'b0,1'b1,1'b0,2'd2,3'd0,4'h0,4'h8,30'h0};
      tbl[12] = '{"wrcr_br",       1'b0,1'b0,1'b0,1'b1,1'b1,2'd1,3'd0,4'h0,4'h0,30'h0};
      tbl[13] = '{"busy_br_exrt",  1'b1,1'b0,1'b0,1'b1,1'b1,2'd2,3'd0,4'hF,4'h0,30'h0};

      reset = 1'b0; irq = 8'h00; creg_rd_addr = 5'd0;
      idle();

      // Reset held three cycles
      repeat (3) @(negedge clk);
      #1;
      chk("rst_flush", 32'(flushes), 32'hF);
      chk("rst_stall", 32'(stalls), 32'h0);
      chk("rst_new_pc", 32'(new_pc), 32'h0);
      rd("rst_status", 5'd0, 32'h0);
      rd("rst_int_mask", 5'd5, 32'hFF);
      rd("rst_exp_vector", 5'd3, {EVR, 2'b00});
      reset = 1'b1;
      @(negedge clk); #1;
      chk("boot_flush", 32'(flushes), 32'h8);
      chk("boot_new_pc", 32'(new_pc), 32'(RV));
      @(negedge clk); #1;
      chk("run_flush", 32'(flushes), 32'h0);

      // Registers used by the table
      wrcr(5'd3, 32'h0000_0400);
      wrcr(5'd7, 32'h0000_0200);
      rd("wr_exp_vector", 5'd3, 32'h400);
      rd("wr_epc", 5'd7, 32'h200);

      // Combinational priority table; inputs removed before the next edge
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if_busy = tbl[i].ifb; mem_busy = tbl[i].memb; ld_hazard = tbl[i].ldh;
         id_br_taken = tbl[i].br; mem_en = tbl[i].en; mem_ctrl_op = tbl[i].op;
         mem_exp_code = tbl[i].code;
         #1;
         chk({tbl[i].name, "_stall"}, 32'(stalls), 32'(tbl[i].e_stall));
         chk({tbl[i].name, "_flush"}, 32'(flushes), 32'(tbl[i].e_flush));
         chk({tbl[i].name, "_new_pc"}, 32'(new_pc), 32'(tbl[i].e_pc));
         #1;
         idle();
      end

      // Trap from user mode with interrupts enabled
      wrcr(5'd0, 32'h3);
      @(negedge clk);
      mem_en = 1'b1; mem_exp_code = 3'd5; mem_pc = 30'h40; mem_br_flag = 1'b0;
      #1;
      chk("trap_flush", 32'(flushes), 32'hF);
      chk("trap_new_pc", 32'(new_pc), 32'h100);
      @(negedge clk);
      idle();
      rd("trap_epc", 5'd7, 32'h100);
      rd("trap_cause", 5'd4, 32'h5);
      rd("trap_status", 5'd0, 32'h0);
      rd("trap_pre_status", 5'd1, 32'h3);
      chk("trap_exe_mode", 32'(exe_mode), 32'h0);

      // EXRT back to user mode
      @(negedge clk);
      mem_en = 1'b1; mem_ctrl_op = 2'd2;
      #1;
      chk("exrt_flush", 32'(flushes), 32'hF);
      chk("exrt_new_pc", 32'(new_pc), 32'h40);
      @(negedge clk);
      idle();
      #1;
      chk("exrt_exe_mode", 32'(exe_mode), 32'h1);
      rd("exrt_status", 5'd0, 32'h3);

      // Delay-slot exception at address 0: EPC wraps
      @(negedge clk);
      mem_en = 1'b1; mem_exp_code = 3'd4; mem_pc = 30'h0; mem_br_flag = 1'b1;
      #1;
      chk("dly_new_pc", 32'(new_pc), 32'h100);
      @(negedge clk);
      idle();
      rd("dly_epc", 5'd7, 32'hFFFF_FFFC);
      rd("dly_cause", 5'd4, 32'hC);
      chk("dly_exe_mode", 32'(exe_mode), 32'h0);

      // Exception held off by mem_busy, taken once the bus frees
      @(negedge clk);
      mem_busy = 1'b1; mem_en = 1'b1; mem_exp_code = 3'd3; mem_pc = 30'h55;
      #1;
      chk("hold_stall", 32'(stalls), 32'hF);
      chk("hold_flush", 32'(flushes), 32'h0);
      @(negedge clk);
      rd("hold_epc", 5'd7, 32'hFFFF_FFFC);
      mem_busy = 1'b0;
      #1;
      chk("release_flush", 32'(flushes), 32'hF);
      chk("release_stall", 32'(stalls), 32'h0);
      chk("release_new_pc", 32'(new_pc), 32'h100);
      @(negedge clk);
      idle();
      rd("release_epc", 5'd7, 32'h154);
      rd("release_cause", 5'd4, 32'h3);

      // Interrupt masking
      wrcr(5'd0, 32'h2);
      wrcr(5'd5, 32'hFB);
      irq = 8'h04;
      #1;
      chk("int_detect_on", 32'(int_detect), 32'h1);
      rd("irq_read", 5'd6, 32'h4);
      @(negedge clk);
      mem_en = 1'b1; mem_ctrl_op = 2'd1; mem_dst_addr = 5'd5; mem_out = 32'hFF;
      #1;
      chk("mask_no_bypass", 32'(int_detect), 32'h1);
      rd("mask_old", 5'd5, 32'hFB);
      @(negedge clk);
      idle();
      #1;
      chk("int_detect_masked", 32'(int_detect), 32'h0);
      rd("mask_new", 5'd5, 32'hFF);

      // Interrupt pending while an exception is taken
      wrcr(5'd5, 32'hFB);
      #1;
      chk("int_before_exp", 32'(int_detect), 32'h1);
      @(negedge clk);
      mem_en = 1'b1; mem_exp_code = 3'd1; mem_pc = 30'h10;
      #1;
      chk("int_exp_flush", 32'(flushes), 32'hF);
      @(negedge clk);
      idle();
      #1;
      chk("int_after_exp", 32'(int_detect), 32'h0);
      rd("int_exp_cause", 5'd4, 32'h1);

      // Writes to IRQ and unmapped addresses are dropped
      wrcr(5'd6, 32'hFF);
      irq = 8'h00;
      rd("irq_unwritable", 5'd6, 32'h0);
      wrcr(5'd9, 32'hABCD);
      rd("addr9_zero", 5'd9, 32'h0);

      // Reset mid-operation
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      if_busy = 1'b1;
      #1;
      chk("mid_rst_flush", 32'(flushes), 32'hF);
      chk("mid_rst_stall", 32'(stalls), 32'h0);
      rd("mid_rst_int_mask", 5'd5, 32'hFF);
      rd("mid_rst_epc", 5'd7, 32'h0);
      if_busy = 1'b0;
      reset = 1'b1;
      @(negedge clk); #1;
      chk("mid_boot_flush", 32'(flushes), 32'h8);
      chk("mid_boot_new_pc", 32'(new_pc), 32'(RV));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
